// File: rtl/adc_scan_ctrl_if.sv
// Conversion handshake between adc_scan_ctrl and the ADC SPI engine.
//   conv_start : one-cycle frame start (controller -> engine)
//   conv_addr  : channel address shifted out in the frame (controller -> engine)
//   conv_done  : one-cycle frame complete (engine -> controller)
//   conv_data  : result for the address sent in the previous frame (engine -> controller)
interface adc_scan_ctrl_if;
  logic       conv_start;
  logic [2:0] conv_addr;
  logic       conv_done;
  logic [7:0] conv_data;

  modport master (output conv_start, conv_addr, input conv_done, conv_data);
  modport slave  (input conv_start, conv_addr, output conv_done, conv_data);
endinterface

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: sweeps the masked channels of an ADC088S102 through its SPI
// engine, realigns the one-frame result pipeline, filters jitter with
// per-channel hysteresis and keeps results in a readable bank with sticky
// change flags.
//   clk, reset_n          : system clock, synchronous active-low reset
//   enable, ch_mask       : run control and channel selection
//   conv                  : handshake to the SPI engine (master side)
//   rd_addr / rd_data     : bank read port, 1-cycle latency
//   changed / clr_changed : sticky change flags, write-1-to-clear
//   sweep_done            : pulse when the highest masked channel is stored
//
// state | meaning
// IDLE  | stopped; waits for enable with a non-empty mask
// ISSUE | one cycle; launches a frame for next_ch
// WAIT  | frame outstanding; processes result or times out
// GAP   | idle spacing between sweeps
module adc_scan_ctrl #(
  parameter int unsigned HYST     = 2,
  parameter int unsigned SCAN_GAP = 1000,
  parameter int unsigned TIMEOUT  = 4095
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [7:0]             ch_mask,
  adc_scan_ctrl_if.master        conv,
  input  logic [2:0]             rd_addr,
  output logic [7:0]             rd_data,
  output logic [7:0]             changed,
  input  logic [7:0]             clr_changed,
  output logic                   sweep_done
);

  localparam int TMR_W = $clog2(TIMEOUT + 2);
  localparam int GAP_W = $clog2(SCAN_GAP + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t            state;
  logic [2:0]        next_ch;
  logic [2:0]        prev_addr;
  logic              primed;
  logic              stop_req;
  logic [TMR_W-1:0]  timer;
  logic [GAP_W-1:0]  gap_cnt;
  logic [7:0]        bank [8];
  logic [7:0]        valid;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] highest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Lowest set bit strictly above cur, wrapping to the lowest set bit.
  function automatic logic [2:0] next_set_above(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    r = lowest_set(m);
    for (int i = 7; i >= 0; i--) if (m[i] && (3'(i) > cur)) r = 3'(i);
    return r;
  endfunction

  logic       stop_now;
  logic       take;
  logic       last_hit;
  logic [7:0] stored;
  logic [8:0] diff;
  logic [8:0] abs_diff;
  logic       do_update;
  logic [7:0] chg_set;

  assign stop_now = !enable || (ch_mask == 8'd0);
  // Results only count once the pipeline holds a real address (primed).
  assign take     = (state == WAIT) && conv.conv_done && primed;
  assign last_hit = primed && (ch_mask != 8'd0) && (prev_addr == highest_set(ch_mask));
  assign stored   = bank[prev_addr];
  assign diff     = {1'b0, conv.conv_data} - {1'b0, stored};
  assign abs_diff = diff[8] ? (9'd0 - diff) : diff;

  always_comb begin
    do_update = 1'b0;
    chg_set   = 8'd0;
    if (take) begin
      if (!valid[prev_addr]) begin
        do_update          = 1'b1;
        chg_set[prev_addr] = (conv.conv_data != 8'd0);
      end else if ((32'(abs_diff) >= HYST) && (conv.conv_data != stored)) begin
        do_update          = 1'b1;
        chg_set[prev_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      conv.conv_start <= 1'b0;
      conv.conv_addr  <= 3'd0;
      prev_addr       <= 3'd0;
      next_ch         <= 3'd0;
      primed          <= 1'b0;
      stop_req        <= 1'b0;
      timer           <= '0;
      gap_cnt         <= '0;
      sweep_done      <= 1'b0;
    end else begin
      conv.conv_start <= 1'b0;
      sweep_done      <= 1'b0;
      case (state)
        IDLE: begin
          stop_req <= 1'b0;
          if (!stop_now) begin
            next_ch <= lowest_set(ch_mask);
            primed  <= 1'b0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          conv.conv_start <= 1'b1;
          conv.conv_addr  <= next_ch;
          prev_addr       <= conv.conv_addr;
          timer           <= TMR_W'(TIMEOUT);
          if (stop_now) stop_req <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (conv.conv_done) begin
            primed  <= 1'b1;
            next_ch <= next_set_above(ch_mask, conv.conv_addr);
            if (last_hit) sweep_done <= 1'b1;
            if (stop_now || stop_req) begin
              state <= IDLE;
            end else if (last_hit && (SCAN_GAP != 0)) begin
              gap_cnt <= GAP_W'((SCAN_GAP > 0) ? (SCAN_GAP - 1) : 0);
              state   <= GAP;
            end else begin
              state <= ISSUE;
            end
          end else if (timer == '0) begin
            // Abandoned frame breaks the address pipeline: retry and re-prime.
            primed  <= 1'b0;
            next_ch <= conv.conv_addr;
            state   <= (stop_now || stop_req) ? IDLE : ISSUE;
          end else begin
            timer <= timer - 1'b1;
            if (stop_now) stop_req <= 1'b1;
          end
        end
        GAP: begin
          if (stop_now) begin
            state <= IDLE;
          end else if (gap_cnt == '0) begin
            state <= ISSUE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'd0;
      valid   <= 8'd0;
      changed <= 8'd0;
      rd_data <= 8'd0;
    end else begin
      rd_data <= bank[rd_addr];
      // Set has priority over a same-cycle clear.
      changed <= (changed & ~clr_changed) | chg_set;
      if (do_update) begin
        bank[prev_addr]  <= conv.conv_data;
        valid[prev_addr] <= 1'b1;
      end
    end
  end

endmodule
